// File: rtl/mux_arb_pkg_v.sv
// rtl/mux_arb_pkg_v.sv - shared constants and types for the 4:1 arbitrating mux
// Purpose: channel count, channel index constants, FSM state encoding and a
//          one-hot decode helper shared by the arbiter and the top level.
// Ports:   none (package).
package mux_arb_pkg_v;

   localparam int NUM_CH = 4;

   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_B = 2'd1;
   localparam logic [1:0] CH_C = 2'd2;
   localparam logic [1:0] CH_D = 2'd3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/rr_arb_4_v.sv
// rtl/rr_arb_4_v.sv - combinational 4-way round-robin arbiter
// Purpose: picks the first requester after the last-served pointer, searching
//          ptr+1, ptr+2, ptr+3, ptr (mod 4).
// Ports:   req     - request vector, bit k = channel k
//          ptr     - index of the most recently served channel
//          gnt_vld - some request is present
//          gnt_idx - binary index of the granted channel
module rr_arb_4_v
   import mux_arb_pkg_v::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [1:0]        ptr,
   output logic              gnt_vld,
   output logic [1:0]        gnt_idx
);

   logic [1:0] cand;

   // Walk from lowest to highest priority; the last hit overwrites earlier
   // ones, so ptr+1 ends up winning whenever it requests.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = ptr;
      cand    = ptr;
      for (int i = NUM_CH; i >= 1; i--) begin
         cand = ptr + 2'(i);
         if (req[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

endmodule

// File: rtl/mux_4_1_arb_v.sv
// rtl/mux_4_1_arb_v.sv - 4:1 merging mux with round-robin arbitration and packet lock
// Purpose: merges channels a..d onto one registered output stream, tagging each
//          beat with its source index; optionally holds a grant for a packet.
// Ports:   i_clk, i_rst           - clock, asynchronous active-high reset
//          i_valid, i_last        - per-channel valid and end-of-packet
//          i_data_a..i_data_d     - per-channel data
//          o_ready                - per-channel ready (combinational, one-hot or 0)
//          o_valid, o_data,
//          o_last, o_sel_code     - registered output beat and its source index
//          i_ready                - downstream ready
module mux_4_1_arb_v
   import mux_arb_pkg_v::*;
#(
   parameter int WIDTH    = 8,
   parameter bit PKT_LOCK = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NUM_CH-1:0] i_valid,
   input  logic [NUM_CH-1:0] i_last,
   input  logic [WIDTH-1:0]  i_data_a,
   input  logic [WIDTH-1:0]  i_data_b,
   input  logic [WIDTH-1:0]  i_data_c,
   input  logic [WIDTH-1:0]  i_data_d,
   output logic [NUM_CH-1:0] o_ready,
   output logic              o_valid,
   output logic [WIDTH-1:0]  o_data,
   output logic              o_last,
   output logic [1:0]        o_sel_code,
   input  logic              i_ready
);

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       lock_ch_q, lock_ch_d;
   logic             o_valid_q, o_valid_d;
   logic [WIDTH-1:0] o_data_q, o_data_d;
   logic             o_last_q, o_last_d;
   logic [1:0]       o_sel_q, o_sel_d;

   logic             gnt_vld;
   logic [1:0]       gnt_idx;
   logic             load;
   logic             xfer;
   logic [1:0]       sel_idx;
   logic [WIDTH-1:0] sel_data;

   rr_arb_4_v u_arb (
      .req     (i_valid),
      .ptr     (ptr_q),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      load = !o_valid_q || i_ready;

      // While locked the arbiter result is ignored; only the locked channel
      // may see ready, even when it has nothing to send.
      if (state_q == ST_LOCKED) begin
         sel_idx = lock_ch_q;
         o_ready = load ? ch_onehot(lock_ch_q) : '0;
      end else begin
         sel_idx = gnt_idx;
         o_ready = (load && gnt_vld) ? ch_onehot(gnt_idx) : '0;
      end

      xfer = |(i_valid & o_ready);

      case (sel_idx)
         CH_A:    sel_data = i_data_a;
         CH_B:    sel_data = i_data_b;
         CH_C:    sel_data = i_data_c;
         default: sel_data = i_data_d;
      endcase

      state_d   = state_q;
      ptr_d     = ptr_q;
      lock_ch_d = lock_ch_q;
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      o_last_d  = o_last_q;
      o_sel_d   = o_sel_q;

      if (xfer) begin
         o_valid_d = 1'b1;
         o_data_d  = sel_data;
         o_last_d  = i_last[sel_idx];
         o_sel_d   = sel_idx;
         if (state_q == ST_IDLE) begin
            ptr_d = sel_idx;
            if (PKT_LOCK && !i_last[sel_idx]) begin
               state_d   = ST_LOCKED;
               lock_ch_d = sel_idx;
            end
         end else if (i_last[sel_idx]) begin
            state_d = ST_IDLE;
         end
      end else if (load) begin
         // Output drained (or was empty) with nothing new: bubble, keep payload.
         o_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= CH_D;
         lock_ch_q <= CH_A;
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_last_q  <= 1'b0;
         o_sel_q   <= 2'd0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         lock_ch_q <= lock_ch_d;
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         o_last_q  <= o_last_d;
         o_sel_q   <= o_sel_d;
      end
   end

   assign o_valid    = o_valid_q;
   assign o_data     = o_data_q;
   assign o_last     = o_last_q;
   assign o_sel_code = o_sel_q;

endmodule

// File: tb/tb_mux_4_1_arb_v.sv
// tb/tb_mux_4_1_arb_v.sv - self-checking bench for mux_4_1_arb_v
module tb_mux_4_1_arb_v;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic [3:0] i_valid;
   logic [3:0] i_last;
   logic [7:0] dat [4];
   logic       i_ready;
   logic [3:0] o_ready;
   logic       o_valid;
   logic [7:0] o_data;
   logic       o_last;
   logic [1:0] o_sel_code;

   int total = 0;
   int bad   = 0;

   // reference model state
   int         m_ptr;
   bit         m_locked;
   int         m_lock;
   bit         m_ov;
   logic [7:0] m_od;
   bit         m_ol;
   int         m_os;

   mux_4_1_arb_v #(.WIDTH(8), .PKT_LOCK(1'b1)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_valid    (i_valid),
      .i_last     (i_last),
      .i_data_a   (dat[0]),
      .i_data_b   (dat[1]),
      .i_data_c   (dat[2]),
      .i_data_d   (dat[3]),
      .o_ready    (o_ready),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_last     (o_last),
      .o_sel_code (o_sel_code),
      .i_ready    (i_ready)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [3:0] model_ready();
      if (m_ov && !i_ready) return 4'b0000;
      if (m_locked) return 4'(1 << m_lock);
      for (int i = 1; i <= 4; i++) begin
         int c;
         c = (m_ptr + i) % 4;
         if (i_valid[c]) return 4'(1 << c);
      end
      return 4'b0000;
   endfunction

   function automatic logic [11:0] model_out();
      return {m_ov, m_ol, 2'(m_os), m_od};
   endfunction

   task automatic model_reset();
      m_ptr = 3; m_locked = 0; m_lock = 0;
      m_ov = 0; m_od = 8'h00; m_ol = 0; m_os = 0;
   endtask

   // One clock: model advances on the rising edge, returns at the falling edge.
   task automatic advance();
      logic [3:0] r;
      int k;
      r = model_ready();
      @(posedge i_clk);
      k = -1;
      for (int i = 0; i < 4; i++) if (i_valid[i] && r[i]) k = i;
      if (k >= 0) begin
         m_ov = 1; m_od = dat[k]; m_ol = i_last[k]; m_os = k;
         if (!m_locked) begin
            m_ptr = k;
            if (!i_last[k]) begin m_locked = 1; m_lock = k; end
         end else if (i_last[k]) begin
            m_locked = 0;
         end
      end else if (!m_ov || i_ready) begin
         m_ov = 0;
      end
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_rst = 1'b1; i_valid = 4'b0; i_last = 4'b0; i_ready = 1'b1;
      for (int i = 0; i < 4; i++) dat[i] = 8'h00;
      model_reset();
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_valid = 4'b0; i_last = 4'b0; i_ready = 1'b1;
      for (int i = 0; i < 4; i++) dat[i] = 8'h00;
      model_reset();
      #12;
      total++;
      if ({o_valid, o_last, o_sel_code, o_data} !== 12'h000) begin
         bad++; $display("FAIL reset_out got %h exp %h", {o_valid, o_last, o_sel_code, o_data}, 12'h000);
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      total++;
      if (o_ready !== 4'b0000) begin
         bad++; $display("FAIL reset_ready got %b exp %b", o_ready, 4'b0000);
      end
   endtask

   task automatic test_single();
      do_reset();
      i_valid = 4'b0100; i_last = 4'b0100; dat[2] = 8'h3C; i_ready = 1'b1;
      #1;
      total++;
      if (o_ready !== 4'b0100) begin
         bad++; $display("FAIL single_ready got %b exp %b", o_ready, 4'b0100);
      end
      advance();
      total++;
      if ({o_valid, o_last, o_sel_code, o_data} !== {1'b1, 1'b1, 2'd2, 8'h3C}) begin
         bad++; $display("FAIL single_out got %h exp %h", {o_valid, o_last, o_sel_code, o_data}, {1'b1, 1'b1, 2'd2, 8'h3C});
      end
      i_valid = 4'b0000;
      advance();
      total++;
      if ({o_valid, o_last, o_sel_code, o_data} !== {1'b0, 1'b1, 2'd2, 8'h3C}) begin
         bad++; $display("FAIL single_bubble got %h exp %h", {o_valid, o_last, o_sel_code, o_data}, {1'b0, 1'b1, 2'd2, 8'h3C});
      end
   endtask

   task automatic test_fairness();
      do_reset();
      i_valid = 4'hF; i_last = 4'hF;
      dat[0] = 8'hA0; dat[1] = 8'hB1; dat[2] = 8'hC2; dat[3] = 8'hD3;
      for (int k = 0; k < 8; k++) begin
         #1;
         total++;
         if (o_ready !== 4'(1 << (k % 4))) begin
            bad++; $display("FAIL fair_ready[%0d] got %b exp %b", k, o_ready, 4'(1 << (k % 4)));
         end
         advance();
         total++;
         if ({o_valid, o_last, o_sel_code, o_data} !== {1'b1, 1'b1, 2'(k % 4), dat[k % 4]}) begin
            bad++; $display("FAIL fair_out[%0d] got %h exp %h", k, {o_valid, o_last, o_sel_code, o_data}, {1'b1, 1'b1, 2'(k % 4), dat[k % 4]});
         end
      end
   endtask

   task automatic test_packet_lock();
      logic [7:0] bd [3];
      bd[0] = 8'h21; bd[1] = 8'h22; bd[2] = 8'h23;
      do_reset();
      // one single-beat packet from a moves the pointer to a
      i_valid = 4'b0001; i_last = 4'b0001; dat[0] = 8'h11;
      advance();
      i_valid = 4'b1111; dat[2] = 8'h33; dat[3] = 8'h44;
      for (int j = 0; j < 3; j++) begin
         dat[1] = bd[j];
         i_last = (j == 2) ? 4'b1111 : 4'b1101;
         #1;
         total++;
         if (o_ready !== 4'b0010) begin
            bad++; $display("FAIL lock_ready[%0d] got %b exp %b", j, o_ready, 4'b0010);
         end
         advance();
         total++;
         if ({o_valid, o_last, o_sel_code, o_data} !== {1'b1, (j == 2), 2'd1, bd[j]}) begin
            bad++; $display("FAIL lock_out[%0d] got %h exp %h", j, {o_valid, o_last, o_sel_code, o_data}, {1'b1, (j == 2), 2'd1, bd[j]});
         end
      end
      i_valid = 4'b1101;
      #1;
      total++;
      if (o_ready !== 4'b0100) begin
         bad++; $display("FAIL lock_next_ready got %b exp %b", o_ready, 4'b0100);
      end
      advance();
      total++;
      if ({o_valid, o_last, o_sel_code, o_data} !== {1'b1, 1'b1, 2'd2, 8'h33}) begin
         bad++; $display("FAIL lock_next_out got %h exp %h", {o_valid, o_last, o_sel_code, o_data}, {1'b1, 1'b1, 2'd2, 8'h33});
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      i_valid = 4'b0001; i_last = 4'b0001; dat[0] = 8'h5A;
      advance();
      i_ready = 1'b0; dat[0] = 8'h77;
      for (int j = 0; j < 5; j++) begin
         #1;
         total++;
         if (o_ready !== 4'b0000) begin
            bad++; $display("FAIL bp_ready[%0d] got %b exp %b", j, o_ready, 4'b0000);
         end
         advance();
         total++;
         if ({o_valid, o_last, o_sel_code, o_data} !== {1'b1, 1'b1, 2'd0, 8'h5A}) begin
            bad++; $display("FAIL bp_hold[%0d] got %h exp %h", j, {o_valid, o_last, o_sel_code, o_data}, {1'b1, 1'b1, 2'd0, 8'h5A});
         end
      end
      i_ready = 1'b1;
      #1;
      total++;
      if (o_ready !== 4'b0001) begin
         bad++; $display("FAIL bp_release_ready got %b exp %b", o_ready, 4'b0001);
      end
      advance();
      total++;
      if ({o_valid, o_last, o_sel_code, o_data} !== {1'b1, 1'b1, 2'd0, 8'h77}) begin
         bad++; $display("FAIL bp_next got %h exp %h", {o_valid, o_last, o_sel_code, o_data}, {1'b1, 1'b1, 2'd0, 8'h77});
      end
      i_valid = 4'b0000;
      advance();
      total++;
      if (o_valid !== 1'b0) begin
         bad++; $display("FAIL bp_nodup got %b exp %b", o_valid, 1'b0);
      end
   endtask

   task automatic test_lock_gap();
      do_reset();
      i_valid = 4'b1000; i_last = 4'b0000; dat[3] = 8'hD1;
      advance();
      i_valid = 4'b0001; i_last = 4'b0001; dat[0] = 8'hA5;
      for (int j = 0; j < 2; j++) begin
         #1;
         total++;
         if (o_ready !== 4'b1000) begin
            bad++; $display("FAIL gap_ready[%0d] got %b exp %b", j, o_ready, 4'b1000);
         end
         advance();
         total++;
         if ({o_valid, o_last, o_sel_code, o_data} !== {1'b0, 1'b0, 2'd3, 8'hD1}) begin
            bad++; $display("FAIL gap_out[%0d] got %h exp %h", j, {o_valid, o_last, o_sel_code, o_data}, {1'b0, 1'b0, 2'd3, 8'hD1});
         end
      end
      i_valid = 4'b1001; i_last = 4'b1001; dat[3] = 8'hD2;
      #1;
      total++;
      if (o_ready !== 4'b1000) begin
         bad++; $display("FAIL gap_resume_ready got %b exp %b", o_ready, 4'b1000);
      end
      advance();
      total++;
      if ({o_valid, o_last, o_sel_code, o_data} !== {1'b1, 1'b1, 2'd3, 8'hD2}) begin
         bad++; $display("FAIL gap_resume_out got %h exp %h", {o_valid, o_last, o_sel_code, o_data}, {1'b1, 1'b1, 2'd3, 8'hD2});
      end
      i_valid = 4'b0001;
      #1;
      total++;
      if (o_ready !== 4'b0001) begin
         bad++; $display("FAIL gap_a_ready got %b exp %b", o_ready, 4'b0001);
      end
      advance();
      total++;
      if ({o_valid, o_last, o_sel_code, o_data} !== {1'b1, 1'b1, 2'd0, 8'hA5}) begin
         bad++; $display("FAIL gap_a_out got %h exp %h", {o_valid, o_last, o_sel_code, o_data}, {1'b1, 1'b1, 2'd0, 8'hA5});
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      i_valid = 4'b0001; i_last = 4'b0000; dat[0] = 8'hE1;
      advance();
      total++;
      if ({o_valid, o_last, o_sel_code, o_data} !== {1'b1, 1'b0, 2'd0, 8'hE1}) begin
         bad++; $display("FAIL mid_locked got %h exp %h", {o_valid, o_last, o_sel_code, o_data}, {1'b1, 1'b0, 2'd0, 8'hE1});
      end
      i_valid = 4'b0011; dat[0] = 8'hE2;
      #2;
      i_rst = 1'b1;
      model_reset();
      #1;
      total++;
      if ({o_valid, o_last, o_sel_code, o_data} !== 12'h000) begin
         bad++; $display("FAIL mid_async got %h exp %h", {o_valid, o_last, o_sel_code, o_data}, 12'h000);
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      i_valid = 4'b0010; i_last = 4'b0010; dat[1] = 8'hB7;
      #1;
      total++;
      if (o_ready !== 4'b0010) begin
         bad++; $display("FAIL mid_b_ready got %b exp %b", o_ready, 4'b0010);
      end
      advance();
      total++;
      if ({o_valid, o_last, o_sel_code, o_data} !== {1'b1, 1'b1, 2'd1, 8'hB7}) begin
         bad++; $display("FAIL mid_b_out got %h exp %h", {o_valid, o_last, o_sel_code, o_data}, {1'b1, 1'b1, 2'd1, 8'hB7});
      end
   endtask

   task automatic test_random();
      bit         pv [4];
      logic [7:0] pd [4];
      bit         pl [4];
      logic [3:0] r;
      do_reset();
      for (int i = 0; i < 4; i++) begin pv[i] = 0; pd[i] = 8'h00; pl[i] = 0; end
      for (int n = 0; n < 400; n++) begin
         // a source keeps its beat until accepted, then may offer a new one
         for (int i = 0; i < 4; i++) begin
            if (!pv[i] && $urandom_range(0, 2) != 0) begin
               pv[i] = 1;
               pd[i] = 8'($urandom);
               pl[i] = ($urandom_range(0, 3) == 0);
            end
            i_valid[i] = pv[i];
            i_last[i]  = pl[i];
            dat[i]     = pd[i];
         end
         i_ready = ($urandom_range(0, 3) != 0);
         #1;
         r = model_ready();
         total++;
         if (o_ready !== r) begin
            bad++; $display("FAIL rand_ready[%0d] got %b exp %b", n, o_ready, r);
         end
         advance();
         for (int i = 0; i < 4; i++) if (r[i] && pv[i]) pv[i] = 0;
         total++;
         if ({o_valid, o_last, o_sel_code, o_data} !== model_out()) begin
            bad++; $display("FAIL rand_out[%0d] got %h exp %h", n, {o_valid, o_last, o_sel_code, o_data}, model_out());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_packet_lock();
      test_backpressure();
      test_lock_gap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
